// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high/low pulse widths on a synchronised line,
// assembles GRB pixels MSB-first and flags frame latches and protocol errors.
module ws2812_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int MIN_HIGH   = 5,
    parameter int BIT_THRESH = 30,
    parameter int MAX_HIGH   = 60,
    parameter int RESET_CYC  = 2500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       din,
    output logic [7:0] data_g,
    output logic [7:0] data_r,
    output logic [7:0] data_b,
    output logic       pixel_valid,
    output logic [7:0] pixel_index,
    output logic       frame_done,
    output logic       err
);

    localparam logic [7:0]  MIN_H   = 8'(MIN_HIGH);
    localparam logic [7:0]  BIT_T   = 8'(BIT_THRESH);
    localparam logic [7:0]  MAX_H_M = 8'(MAX_HIGH - 1);
    localparam logic [11:0] RST_C_M = 12'(RESET_CYC - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, din_s_q, din_q;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [11:0] lcnt_q, lcnt_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic        pix_seen_q, pix_seen_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  data_g_q, data_g_d, data_r_q, data_r_d, data_b_q, data_b_d;
    logic [7:0]  pixel_index_q, pixel_index_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic        rise, fall;
    logic [23:0] shift_next;

    assign rise       = din_s_q & ~din_q;
    assign fall       = ~din_s_q & din_q;
    assign shift_next = {shift_q[22:0], (hcnt_q >= BIT_T)};

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bcnt_d        = bcnt_q;
        pcnt_d        = pcnt_q;
        pix_seen_d    = pix_seen_q;
        shift_d       = shift_q;
        data_g_d      = data_g_q;
        data_r_d      = data_r_q;
        data_b_d      = data_b_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d     = '0;
                pcnt_d     = '0;
                pix_seen_d = 1'b0;
                shift_d    = '0;
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = 8'd1;
                end
            end
            HIGH: begin
                // The falling edge wins over the stuck-high threshold on the same cycle.
                if (fall) begin
                    lcnt_d = 12'd1;
                    if (hcnt_q < MIN_H) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOW;
                        shift_d = shift_next;
                        if (bcnt_q == 5'd23) begin
                            data_g_d      = shift_next[23:16];
                            data_r_d      = shift_next[15:8];
                            data_b_d      = shift_next[7:0];
                            pixel_index_d = pcnt_q;
                            pixel_valid_d = 1'b1;
                            bcnt_d        = '0;
                            pcnt_d        = pcnt_q + 8'd1;
                            pix_seen_d    = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + 5'd1;
                        end
                    end
                end else if (hcnt_q >= MAX_H_M) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    lcnt_d  = '0;
                end else if (hcnt_q != 8'hFF) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = 8'd1;
                end else if (lcnt_q >= RST_C_M) begin
                    // Latch: a partial pixel is an error and is dropped.
                    state_d = IDLE;
                    if (bcnt_q != 5'd0) err_d = 1'b1;
                    else                frame_done_d = pix_seen_q;
                end else if (lcnt_q != 12'hFFF) begin
                    lcnt_d = lcnt_q + 12'd1;
                end
            end
            ERROR: begin
                if (din_s_q) begin
                    lcnt_d = '0;
                end else if (lcnt_q >= RST_C_M) begin
                    state_d = IDLE;
                end else if (lcnt_q != 12'hFFF) begin
                    lcnt_d = lcnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q       <= 1'b0;
            din_s_q       <= 1'b0;
            din_q         <= 1'b0;
            state_q       <= IDLE;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bcnt_q        <= '0;
            pcnt_q        <= '0;
            pix_seen_q    <= 1'b0;
            shift_q       <= '0;
            data_g_q      <= '0;
            data_r_q      <= '0;
            data_b_q      <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            sync1_q       <= din;
            din_s_q       <= sync1_q;
            din_q         <= din_s_q;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bcnt_q        <= bcnt_d;
            pcnt_q        <= pcnt_d;
            pix_seen_q    <= pix_seen_d;
            shift_q       <= shift_d;
            data_g_q      <= data_g_d;
            data_r_q      <= data_r_d;
            data_b_q      <= data_b_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    assign data_g      = data_g_q;
    assign data_r      = data_r_q;
    assign data_b      = data_b_q;
    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives pulse-width encoded pixels, scores decoded pixels
// against an expected queue and tallies frame_done / err pulses.
module tb_ws2812_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       din     = 1'b0;
    logic [7:0] data_g, data_r, data_b, pixel_index;
    logic       pixel_valid, frame_done, err;

    ws2812_rx dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .din         (din),
        .data_g      (data_g),
        .data_r      (data_r),
        .data_b      (data_b),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 sys_clk = ~sys_clk;

    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          err_cnt = 0;
    int          exp_fd = 0;
    int          exp_err = 0;
    int          pix_idx = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_e;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pixel_valid pops one expected {index, g, r, b}.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (pixel_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexp_pix", {pixel_index, data_g, data_r, data_b}, 32'hDEAD_BEEF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("pixel", {pixel_index, data_g, data_r, data_b}, exp_e);
                end
            end
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic drive_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_hl(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge sys_clk);
        din = 1'b0;
        repeat (l) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_hl(40, 22);
        else   send_hl(20, 42);
    endtask

    task automatic send_bits(input logic [23:0] p, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(p[i]);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        exp_q.push_back({8'(pix_idx), p});
        pix_idx++;
        send_bits(p, 24);
    endtask

    task automatic latch();
        drive_low(3000);
        if (pix_idx > 0) exp_fd++;
        pix_idx = 0;
    endtask

    task automatic phase_check(input string tag);
        check_eq({tag, "_pend"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_fd"}, 32'(fd_cnt), 32'(exp_fd));
        check_eq({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_data"}, {pixel_index, data_g, data_r, data_b}, 32'd0);
        check_eq({tag, "_flags"}, {29'd0, pixel_valid, frame_done, err}, 32'd0);
    endtask

    initial begin
        #2 sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_zero("reset");
        sys_rst = 1'b0;
        drive_low(10);

        send_pixel(24'hFF0000);
        latch();
        phase_check("one_pix");

        send_pixel(24'h123456);
        send_pixel(24'hABCDEF);
        send_pixel(24'h000001);
        latch();
        phase_check("three_pix");

        // Boundary high times: 29 cycles is a 0, 30 cycles is a 1.
        exp_q.push_back({8'(pix_idx), 24'h000001});
        pix_idx++;
        send_bits(24'h000000, 22);
        send_hl(29, 33);
        send_hl(30, 32);
        latch();
        phase_check("thresh");

        send_bits(24'hF00000, 5);
        send_hl(3, 0);
        drive_low(2600);
        exp_err++;
        pix_idx = 0;
        phase_check("glitch");
        send_pixel(24'hA5C33C);
        latch();
        phase_check("after_glitch");

        send_bits(24'hABC000, 12);
        drive_low(3000);
        exp_err++;
        pix_idx = 0;
        phase_check("partial");
        send_pixel(24'h5A5A5A);
        latch();
        phase_check("after_partial");

        send_hl(100, 2600);
        exp_err++;
        phase_check("stuck");
        send_pixel(24'hC0FFEE);
        latch();
        phase_check("after_stuck");

        // Reset lands in the middle of the tenth bit.
        send_bits(24'h00FF00, 9);
        din = 1'b1;
        repeat (10) @(negedge sys_clk);
        sys_rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_zero("mid_rst");
        sys_rst = 1'b0;
        pix_idx = 0;
        drive_low(20);
        send_pixel(24'h00FF00);
        latch();
        phase_check("after_rst");
        check_eq("rst_data_r", {24'd0, data_r}, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
